// File: rtl/data_mem_req_pkg.sv
// data_mem_req_pkg: shared state encoding, access-size codes and default widths
package data_mem_req_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, DROP} state_e;
endpackage

// File: rtl/data_mem_req_if.sv
// data_mem_req_if: translated-address request, SRAM-like bus and MEM-stage response signals
interface data_mem_req_if
    import data_mem_req_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic                flush;
    logic [ADDR_W-1:0]   paddr;
    logic                uncached_en;
    logic                paddr_valid;
    logic                paddr_ready;
    logic                op_we;
    logic [1:0]          op_size;
    logic [DATA_W/8-1:0] op_wstrb;
    logic [DATA_W-1:0]   op_wdata;
    logic                bus_req;
    logic                bus_wr;
    logic [1:0]          bus_size;
    logic [DATA_W/8-1:0] bus_wstrb;
    logic [ADDR_W-1:0]   bus_addr;
    logic [DATA_W-1:0]   bus_wdata;
    logic                bus_uncached;
    logic                bus_addr_ok;
    logic                bus_data_ok;
    logic [DATA_W-1:0]   bus_rdata;
    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_ready;
    modport master (
        output flush, paddr, uncached_en, paddr_valid, op_we, op_size, op_wstrb, op_wdata,
               bus_addr_ok, bus_data_ok, bus_rdata, rsp_ready,
        input  paddr_ready, bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
               bus_uncached, rsp_valid, rsp_rdata
    );
    modport slave (
        input  flush, paddr, uncached_en, paddr_valid, op_we, op_size, op_wstrb, op_wdata,
               bus_addr_ok, bus_data_ok, bus_rdata, rsp_ready,
        output paddr_ready, bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
               bus_uncached, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/data_mem_req.sv
// data_mem_req: single-outstanding data-side bus requester; latches a translated request,
// drives one SRAM-like transaction and hands load data / store ack back to MEM, flush-aware
module data_mem_req
    import data_mem_req_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input logic          clk,
    input logic          reset,
    data_mem_req_if.slave mif
);
    state_e              state_q, state_d;
    logic                wr_q, wr_d;
    logic [1:0]          size_q, size_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                unc_q, unc_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                accept;

    assign mif.paddr_ready  = (state_q == IDLE) & ~mif.flush;
    assign mif.bus_req      = state_q == REQ;
    assign mif.rsp_valid    = state_q == RESP;
    assign mif.bus_wr       = wr_q;
    assign mif.bus_size     = size_q;
    assign mif.bus_wstrb    = wstrb_q;
    assign mif.bus_addr     = addr_q;
    assign mif.bus_wdata    = wdata_q;
    assign mif.bus_uncached = unc_q;
    assign mif.rsp_rdata    = rdata_q;
    assign accept           = mif.paddr_valid & mif.paddr_ready;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        size_d  = size_q;
        wstrb_d = wstrb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unc_d   = unc_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = REQ;
                wr_d    = mif.op_we;
                size_d  = mif.op_size;
                wstrb_d = mif.op_we ? mif.op_wstrb : '0;
                addr_d  = mif.paddr;
                wdata_d = mif.op_wdata;
                unc_d   = mif.uncached_en;
            end
            // an unaccepted request may be withdrawn; an accepted one must be drained
            REQ:  state_d = mif.bus_addr_ok ? (mif.flush ? DROP : WAIT) : (mif.flush ? IDLE : REQ);
            WAIT: if (mif.bus_data_ok) begin
                state_d = mif.flush ? IDLE : RESP;
                rdata_d = wr_q ? '0 : mif.bus_rdata;
            end else if (mif.flush) begin
                state_d = DROP;
            end
            DROP: state_d = mif.bus_data_ok ? IDLE : DROP;
            RESP: state_d = (mif.rsp_ready | mif.flush) ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= '0;
            wstrb_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            unc_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            wstrb_q <= wstrb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            unc_q   <= unc_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_data_mem_req.sv
// tb_data_mem_req: directed vectors; bus and response expectations are queued and
// checked by a negedge monitor, state/latency points are checked inline
module tb_data_mem_req;
    import data_mem_req_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [71:0] bus_q[$];
    logic [31:0] rsp_q[$];

    data_mem_req_if #(.ADDR_W(32), .DATA_W(32)) mif();
    data_mem_req #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .reset(reset), .mif(mif));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] bus_now();
        return {mif.bus_wr, mif.bus_size, mif.bus_wstrb, mif.bus_addr, mif.bus_wdata, mif.bus_uncached};
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (mif.bus_req && mif.bus_addr_ok) begin
                if (bus_q.size() == 0) chk("bus_unexpected", 80'd1, 80'd0);
                else chk("bus_fields", bus_now(), bus_q.pop_front());
            end
            if (mif.rsp_valid) begin
                if (rsp_q.size() == 0) chk("rsp_unexpected", 80'd1, 80'd0);
                else begin
                    chk("rsp_rdata", mif.rsp_rdata, rsp_q[0]);
                    if (mif.rsp_ready) void'(rsp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic issue(input logic [31:0] a, input logic u, input logic we, input logic [1:0] sz,
                         input logic [3:0] st, input logic [31:0] wd);
        mif.paddr_valid = 1'b1;
        mif.paddr       = a;
        mif.uncached_en = u;
        mif.op_we       = we;
        mif.op_size     = sz;
        mif.op_wstrb    = st;
        mif.op_wdata    = wd;
        #1 chk("paddr_ready_accept", mif.paddr_ready, 1);
    endtask

    task automatic load_zw(input logic [31:0] a, input logic u, input logic [31:0] d);
        issue(a, u, 1'b0, SIZE_W, 4'hF, 32'h0);
        bus_q.push_back({1'b0, SIZE_W, 4'h0, a, 32'h0, u});
        rsp_q.push_back(d);
        tick();
        mif.paddr_valid = 1'b0;
        mif.bus_addr_ok = 1'b1;
        #1 chk("load_bus_req_t1", mif.bus_req, 1);
        chk("load_ready_busy", mif.paddr_ready, 0);
        tick();
        mif.bus_addr_ok = 1'b0;
        mif.bus_data_ok = 1'b1;
        mif.bus_rdata   = d;
        #1 chk("load_req_drop_t2", mif.bus_req, 0);
        chk("load_rsp_t2", mif.rsp_valid, 0);
        tick();
        mif.bus_data_ok = 1'b0;
        mif.rsp_ready   = 1'b1;
        #1 chk("load_rsp_t3", mif.rsp_valid, 1);
        tick();
        mif.rsp_ready = 1'b0;
        #1 chk("load_rsp_done", mif.rsp_valid, 0);
        chk("load_ready_again", mif.paddr_ready, 1);
    endtask

    initial begin
        mif.flush = 0; mif.paddr = 0; mif.uncached_en = 0; mif.paddr_valid = 0;
        mif.op_we = 0; mif.op_size = 0; mif.op_wstrb = 0; mif.op_wdata = 0;
        mif.bus_addr_ok = 0; mif.bus_data_ok = 0; mif.bus_rdata = 0; mif.rsp_ready = 0;
        repeat (3) tick();
        chk("rst_bus_req", mif.bus_req, 0);
        chk("rst_rsp_valid", mif.rsp_valid, 0);
        chk("rst_paddr_ready", mif.paddr_ready, 1);
        chk("rst_bus_fields", bus_now(), 72'h0);
        chk("rst_rsp_rdata", mif.rsp_rdata, 0);
        reset = 1'b1;
        tick();
        // zero-wait uncached load
        load_zw(32'h1C00_0104, 1'b1, 32'hDEAD_BEEF);
        // halfword store with three addr_ok stall cycles
        issue(32'h1C00_0200, 1'b0, 1'b1, SIZE_H, 4'b0011, 32'h0000_1234);
        bus_q.push_back({1'b1, SIZE_H, 4'b0011, 32'h1C00_0200, 32'h0000_1234, 1'b0});
        rsp_q.push_back(32'h0);
        tick();
        mif.paddr_valid = 0; mif.paddr = 32'hFFFF_FFFF; mif.op_we = 0; mif.op_wstrb = 4'hF;
        mif.op_wdata = 32'hAAAA_AAAA; mif.op_size = SIZE_B; mif.uncached_en = 1;
        for (int i = 0; i < 4; i++) begin
            mif.bus_addr_ok = (i == 3);
            #1 chk("store_bus_req", mif.bus_req, 1);
            chk("store_hold", bus_now(), {1'b1, SIZE_H, 4'b0011, 32'h1C00_0200, 32'h0000_1234, 1'b0});
            tick();
        end
        mif.bus_addr_ok = 0; mif.bus_data_ok = 1; mif.bus_rdata = 32'hFFFF_FFFF;
        tick();
        mif.bus_data_ok = 0; mif.rsp_ready = 1;
        #1 chk("store_rsp_valid", mif.rsp_valid, 1);
        tick();
        mif.rsp_ready = 0;
        // flush while REQ is still unaccepted
        issue(32'h0000_0100, 1'b0, 1'b0, SIZE_W, 4'h0, 32'h0);
        tick();
        mif.paddr_valid = 0; mif.flush = 1;
        #1 chk("flreq_bus_req", mif.bus_req, 1);
        tick();
        mif.flush = 0;
        #1 chk("flreq_bus_req_off", mif.bus_req, 0);
        chk("flreq_idle", mif.paddr_ready, 1);
        chk("flreq_no_rsp", mif.rsp_valid, 0);
        load_zw(32'h1C00_0300, 1'b0, 32'h0BAD_F00D);
        // flush in IDLE blocks acceptance
        mif.flush = 1; mif.paddr_valid = 1;
        #1 chk("flidle_ready", mif.paddr_ready, 0);
        tick();
        mif.flush = 0; mif.paddr_valid = 0;
        #1 chk("flidle_no_req", mif.bus_req, 0);
        // flush in WAIT -> DROP until data_ok
        issue(32'h1C00_0400, 1'b1, 1'b0, SIZE_B, 4'h0, 32'h0);
        bus_q.push_back({1'b0, SIZE_B, 4'h0, 32'h1C00_0400, 32'h0, 1'b1});
        tick();
        mif.paddr_valid = 0; mif.bus_addr_ok = 1;
        tick();
        mif.bus_addr_ok = 0; mif.flush = 1;
        tick();
        mif.flush = 0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("drop_ready", mif.paddr_ready, 0);
            chk("drop_no_rsp", mif.rsp_valid, 0);
            tick();
        end
        mif.bus_data_ok = 1; mif.bus_rdata = 32'h5555_5555;
        #1 chk("drop_ready_dok", mif.paddr_ready, 0);
        tick();
        mif.bus_data_ok = 0;
        #1 chk("drop_ready_after", mif.paddr_ready, 1);
        chk("drop_no_rsp_after", mif.rsp_valid, 0);
        // response held, then rsp_ready and flush together
        issue(32'h1C00_0500, 1'b0, 1'b0, SIZE_W, 4'h0, 32'h0);
        bus_q.push_back({1'b0, SIZE_W, 4'h0, 32'h1C00_0500, 32'h0, 1'b0});
        rsp_q.push_back(32'h1357_9BDF);
        tick();
        mif.paddr_valid = 0; mif.bus_addr_ok = 1;
        tick();
        mif.bus_addr_ok = 0; mif.bus_data_ok = 1; mif.bus_rdata = 32'h1357_9BDF;
        tick();
        mif.bus_data_ok = 0; mif.bus_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("hold_rsp_valid", mif.rsp_valid, 1);
            tick();
        end
        mif.rsp_ready = 1; mif.flush = 1;
        tick();
        mif.rsp_ready = 0; mif.flush = 0;
        #1 chk("hold_done", mif.rsp_valid, 0);
        chk("hold_idle", mif.paddr_ready, 1);
        // asynchronous reset while in WAIT
        issue(32'h1C00_0600, 1'b1, 1'b0, SIZE_W, 4'h0, 32'h0);
        bus_q.push_back({1'b0, SIZE_W, 4'h0, 32'h1C00_0600, 32'h0, 1'b1});
        tick();
        mif.paddr_valid = 0; mif.bus_addr_ok = 1;
        tick();
        mif.bus_addr_ok = 0;
        #1 reset = 0;
        #1 chk("arst_bus_req", mif.bus_req, 0);
        chk("arst_rsp_valid", mif.rsp_valid, 0);
        chk("arst_bus_addr", mif.bus_addr, 0);
        tick();
        reset = 1;
        mif.bus_data_ok = 1; mif.bus_rdata = 32'h7777_7777;
        #1 chk("arst_ready", mif.paddr_ready, 1);
        tick();
        mif.bus_data_ok = 0;
        #1 chk("arst_spurious_rsp", mif.rsp_valid, 0);
        chk("arst_spurious_req", mif.bus_req, 0);
        load_zw(32'h1C00_0700, 1'b0, 32'h2468_ACE0);
        repeat (2) tick();
        chk("bus_q_drained", bus_q.size(), 0);
        chk("rsp_q_drained", rsp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
